// File: rtl/regfile_writeback.sv
// Write-side master for the 32x32 register file: buffers ALU/memory results in a FIFO and drains one write per cycle.
// Latency: entry accepted at edge N (FIFO empty, no reads) drives rf_write after edge N+1; the register file commits at edge N+2.
// Backpressure: in_ready = !full (0 during reset); decode reads win arbitration unless the FIFO is full or writes were deferred MAX_DEFER cycles.
//
// Ports:
//   clk, reg_reset                 clock, asynchronous active-high reset
//   in_valid/in_ready              result handshake carrying in_opcode, in_rd, in_data
//   rd_req / rd_stall              decode read request / request not granted this cycle (combinational)
//   rf_read, rf_write              registered register-file read / write enables (never both 1)
//   rf_opcode, rf_reg1,
//   rf_write_data                  registered write payload (holds last value when idle)
//   count, empty                   FIFO occupancy
//   fwd_* (WB_FORWARD_EN only)     combinational lookup of the youngest pending result for two source registers
//
// Optional feature macro: WB_FORWARD_EN
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.

module regfile_writeback #(
    parameter int DEPTH     = 4,
    parameter int MAX_DEFER = 3
) (
    input  logic                     clk,
    input  logic                     reg_reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [5:0]               in_opcode,
    input  logic [4:0]               in_rd,
    input  logic [31:0]              in_data,
    input  logic                     rd_req,
    output logic                     rd_stall,
    output logic                     rf_read,
    output logic                     rf_write,
    output logic [5:0]               rf_opcode,
    output logic [4:0]               rf_reg1,
    output logic [31:0]              rf_write_data,
    output logic [$clog2(DEPTH):0]   count,
`ifdef WB_FORWARD_EN
    input  logic [4:0]               fwd_rs1,
    input  logic [4:0]               fwd_rs2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [31:0]              fwd_data1,
    output logic [31:0]              fwd_data2,
    output logic                     fwd_stall,
`endif
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DEF_W = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_READ,
        GNT_WRITE
    } grant_e;

    // State
    wb_entry_t          mem_q [DEPTH];
    wb_entry_t          mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEF_W-1:0]   defer_q, defer_d;
    logic               rf_read_q, rf_read_d;
    logic               rf_write_q, rf_write_d;
    logic [5:0]         rf_opcode_q, rf_opcode_d;
    logic [4:0]         rf_reg1_q, rf_reg1_d;
    logic [31:0]        rf_write_data_q, rf_write_data_d;

    // Combinational helpers
    logic               full_w;
    logic               empty_w;
    logic               push_w;
    logic               pop_w;
    grant_e             grant;
    wb_entry_t          head;

    assign full_w   = (count_q == CNT_W'(DEPTH));
    assign empty_w  = (count_q == '0);
    // Gating with reset keeps producers from handing over results that would be discarded.
    assign in_ready = !full_w && !reg_reset;
    assign push_w   = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];

    // Reads win unless the FIFO is full or writes have already waited MAX_DEFER cycles;
    // an empty FIFO never blocks a read.
    always_comb begin
        grant = GNT_IDLE;
        if (rd_req && (empty_w || (!full_w && (defer_q < DEF_W'(MAX_DEFER))))) begin
            grant = GNT_READ;
        end else if (!empty_w) begin
            grant = GNT_WRITE;
        end
    end

    assign pop_w    = (grant == GNT_WRITE);
    assign rd_stall = rd_req && (grant != GNT_READ);

    // FIFO storage and pointers. A pop only happens when non-empty, so there is no
    // push-to-pop bypass path; push and pop together leave count unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_w) begin
            mem_d[wr_ptr_q] = '{opcode: in_opcode, rd: in_rd, data: in_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Defer counter: counts consecutive reads granted while writes are waiting.
    always_comb begin
        defer_d = defer_q;
        if (empty_w || (grant == GNT_WRITE)) begin
            defer_d = '0;
        end else if ((grant == GNT_READ) && (defer_q < DEF_W'(MAX_DEFER))) begin
            defer_d = defer_q + DEF_W'(1);
        end
    end

    // Register-file port: payload holds its last value while not writing.
    always_comb begin
        rf_read_d       = (grant == GNT_READ);
        rf_write_d      = (grant == GNT_WRITE);
        rf_opcode_d     = rf_opcode_q;
        rf_reg1_d       = rf_reg1_q;
        rf_write_data_d = rf_write_data_q;
        if (pop_w) begin
            rf_opcode_d     = head.opcode;
            rf_reg1_d       = head.rd;
            rf_write_data_d = head.data;
        end
    end

    always_ff @(posedge clk or posedge reg_reset) begin
        if (reg_reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            defer_q         <= '0;
            rf_read_q       <= 1'b0;
            rf_write_q      <= 1'b0;
            rf_opcode_q     <= '0;
            rf_reg1_q       <= '0;
            rf_write_data_q <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            defer_q         <= defer_d;
            rf_read_q       <= rf_read_d;
            rf_write_q      <= rf_write_d;
            rf_opcode_q     <= rf_opcode_d;
            rf_reg1_q       <= rf_reg1_d;
            rf_write_data_q <= rf_write_data_d;
        end
    end

    // Storage needs no reset: count gates which entries are meaningful.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rf_read       = rf_read_q;
    assign rf_write      = rf_write_q;
    assign rf_opcode     = rf_opcode_q;
    assign rf_reg1       = rf_reg1_q;
    assign rf_write_data = rf_write_data_q;
    assign count         = count_q;
    assign empty         = empty_w;

`ifdef WB_FORWARD_EN
    // LDI, LUI and LB only update part of the register, so their data cannot be forwarded.
    function automatic logic is_partial(input logic [5:0] op);
        return (op == 6'b010000) || (op == 6'b010001) || (op == 6'b011010);
    endfunction

    logic               f1_match, f2_match;
    logic [5:0]         f1_op, f2_op;
    logic [31:0]        f1_data, f2_data;
    logic               f1_partial, f2_partial;
    logic [PTR_W-1:0]   f_idx;

    // Scan oldest to youngest so the last match wins. The write currently on the
    // rf port is older than anything still in the FIFO, so it seeds the search.
    always_comb begin
        f1_match = rf_write_q && (rf_reg1_q == fwd_rs1);
        f1_op    = rf_opcode_q;
        f1_data  = rf_write_data_q;
        f2_match = rf_write_q && (rf_reg1_q == fwd_rs2);
        f2_op    = rf_opcode_q;
        f2_data  = rf_write_data_q;
        f_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            f_idx = rd_ptr_q + PTR_W'(i);
            if (i < int'(count_q)) begin
                if (mem_q[f_idx].rd == fwd_rs1) begin
                    f1_match = 1'b1;
                    f1_op    = mem_q[f_idx].opcode;
                    f1_data  = mem_q[f_idx].data;
                end
                if (mem_q[f_idx].rd == fwd_rs2) begin
                    f2_match = 1'b1;
                    f2_op    = mem_q[f_idx].opcode;
                    f2_data  = mem_q[f_idx].data;
                end
            end
        end
        f1_partial = f1_match && is_partial(f1_op);
        f2_partial = f2_match && is_partial(f2_op);
    end

    assign fwd_hit1  = f1_match && !f1_partial;
    assign fwd_hit2  = f2_match && !f2_partial;
    assign fwd_data1 = fwd_hit1 ? f1_data : 32'h0;
    assign fwd_data2 = fwd_hit2 ? f2_data : 32'h0;
    assign fwd_stall = f1_partial || f2_partial;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed testbench for regfile_writeback (DEPTH=4, MAX_DEFER=3).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Forwarding scenario is compiled only when WB_FORWARD_EN is defined.

module tb_regfile_writeback;

    logic        clk;
    logic        reg_reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        rd_req;
    logic        rd_stall;
    logic        rf_read;
    logic        rf_write;
    logic [5:0]  rf_opcode;
    logic [4:0]  rf_reg1;
    logic [31:0] rf_write_data;
    logic [2:0]  count;
    logic        empty;
`ifdef WB_FORWARD_EN
    logic [4:0]  fwd_rs1;
    logic [4:0]  fwd_rs2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic        fwd_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    regfile_writeback #(.DEPTH(4), .MAX_DEFER(3)) dut (
        .clk           (clk),
        .reg_reset     (reg_reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_rd         (in_rd),
        .in_data       (in_data),
        .rd_req        (rd_req),
        .rd_stall      (rd_stall),
        .rf_read       (rf_read),
        .rf_write      (rf_write),
        .rf_opcode     (rf_opcode),
        .rf_reg1       (rf_reg1),
        .rf_write_data (rf_write_data),
        .count         (count),
`ifdef WB_FORWARD_EN
        .fwd_rs1       (fwd_rs1),
        .fwd_rs2       (fwd_rs2),
        .fwd_hit1      (fwd_hit1),
        .fwd_hit2      (fwd_hit2),
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2),
        .fwd_stall     (fwd_stall),
`endif
        .empty         (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] d);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_data   = d;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %0b exp 1", empty); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
        n_tests++; if ({rf_read, rf_write} !== 2'b00) begin n_fail++; $display("FAIL rst_rf_en got %b exp 00", {rf_read, rf_write}); end
        n_tests++; if ({rf_opcode, rf_reg1, rf_write_data} !== 43'h0) begin n_fail++; $display("FAIL rst_rf_payload got %h exp 0", {rf_opcode, rf_reg1, rf_write_data}); end
        tick();
        tick();
        reg_reset = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_latency();
        rd_req = 1'b0;
        set_entry(6'b000001, 5'd5, 32'hDEADBEEF);
        tick();                              // accept edge N
        in_valid = 1'b0;
        n_tests++; if (rf_write !== 1'b0 || count !== 3'd1) begin n_fail++; $display("FAIL lat_n got wr=%0b cnt=%0d exp wr=0 cnt=1", rf_write, count); end
        tick();                              // edge N+1
        n_tests++; if (rf_write !== 1'b1 || rf_read !== 1'b0) begin n_fail++; $display("FAIL lat_n1_en got wr=%0b rd=%0b exp wr=1 rd=0", rf_write, rf_read); end
        n_tests++; if (rf_reg1 !== 5'd5 || rf_write_data !== 32'hDEADBEEF || rf_opcode !== 6'b000001) begin n_fail++; $display("FAIL lat_n1_payload got op=%h rd=%0d d=%h exp op=01 rd=5 d=deadbeef", rf_opcode, rf_reg1, rf_write_data); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL lat_empty got %0b exp 1", empty); end
        tick();                              // edge N+2
        n_tests++; if (rf_write !== 1'b0 || rf_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat_n2 got wr=%0b d=%h exp wr=0 d=deadbeef", rf_write, rf_write_data); end
    endtask

    task automatic test_defer();
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_entry(6'b000010, 5'(i + 1), 32'h100 + 32'(i));
            n_tests++; if (rd_stall !== 1'b0) begin n_fail++; $display("FAIL defer_fill_stall%0d got %0b exp 0", i, rd_stall); end
            tick();
        end
        in_valid = 1'b0;
        // Full with defer saturated: W R R R repeated until drained, then reads only.
        for (int k = 0; k < 16; k++) begin
            logic exp_w;
            exp_w = ((k % 4) == 0);
            n_tests++; if (rd_stall !== exp_w) begin n_fail++; $display("FAIL defer_stall%0d got %0b exp %0b", k, rd_stall, exp_w); end
            tick();
            if (exp_w) begin
                n_tests++;
                if (rf_write !== 1'b1 || rf_read !== 1'b0 || rf_reg1 !== 5'(k / 4 + 1) || rf_write_data !== 32'h100 + 32'(k / 4)) begin
                    n_fail++;
                    $display("FAIL defer_write%0d got wr=%0b rd=%0d d=%h exp wr=1 rd=%0d d=%h", k, rf_write, rf_reg1, rf_write_data, k / 4 + 1, 32'h100 + 32'(k / 4));
                end
            end else begin
                n_tests++; if (rf_read !== 1'b1 || rf_write !== 1'b0) begin n_fail++; $display("FAIL defer_read%0d got rd=%0b wr=%0b exp rd=1 wr=0", k, rf_read, rf_write); end
            end
        end
        n_tests++; if (empty !== 1'b1 || rd_stall !== 1'b0) begin n_fail++; $display("FAIL defer_end got empty=%0b stall=%0b exp 1 0", empty, rd_stall); end
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_full();
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_entry(6'b000011, 5'(10 + i), 32'h200 + 32'(i));
            tick();
        end
        in_valid = 1'b0;
        n_tests++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_state got cnt=%0d rdy=%0b exp 4 0", count, in_ready); end
        n_tests++; if (rd_stall !== 1'b1) begin n_fail++; $display("FAIL full_stall got %0b exp 1", rd_stall); end
        tick();
        n_tests++; if (rf_write !== 1'b1 || rf_reg1 !== 5'd10 || count !== 3'd3) begin n_fail++; $display("FAIL full_pop got wr=%0b rd=%0d cnt=%0d exp 1 10 3", rf_write, rf_reg1, count); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back got %0b exp 1", in_ready); end
        // Refill with defer only at 0: read is granted while filling, then full forces a write at defer=1.
        set_entry(6'b000011, 5'd14, 32'h204);
        n_tests++; if (rd_stall !== 1'b0) begin n_fail++; $display("FAIL full_refill_stall got %0b exp 0", rd_stall); end
        tick();
        in_valid = 1'b0;
        n_tests++; if (count !== 3'd4 || in_ready !== 1'b0 || rd_stall !== 1'b1) begin n_fail++; $display("FAIL full_immediate got cnt=%0d rdy=%0b stall=%0b exp 4 0 1", count, in_ready, rd_stall); end
        rd_req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            n_tests++; if (rf_write !== 1'b1 || rf_reg1 !== 5'(11 + j) || rf_write_data !== 32'h201 + 32'(j)) begin n_fail++; $display("FAIL full_drain%0d got wr=%0b rd=%0d d=%h exp rd=%0d", j, rf_write, rf_reg1, rf_write_data, 11 + j); end
        end
        tick();
        n_tests++; if (empty !== 1'b1 || rf_write !== 1'b0) begin n_fail++; $display("FAIL full_end got empty=%0b wr=%0b exp 1 0", empty, rf_write); end
    endtask

    task automatic test_same_reg();
        rd_req = 1'b0;
        set_entry(6'b000001, 5'd7, 32'h1);
        tick();
        set_entry(6'b000001, 5'd7, 32'h2);
        tick();
        in_valid = 1'b0;
        n_tests++; if (rf_write !== 1'b1 || rf_reg1 !== 5'd7 || rf_write_data !== 32'h1) begin n_fail++; $display("FAIL order_first got wr=%0b rd=%0d d=%h exp 1 7 1", rf_write, rf_reg1, rf_write_data); end
        tick();
        n_tests++; if (rf_write !== 1'b1 || rf_reg1 !== 5'd7 || rf_write_data !== 32'h2) begin n_fail++; $display("FAIL order_second got wr=%0b rd=%0d d=%h exp 1 7 2", rf_write, rf_reg1, rf_write_data); end
        tick();
        n_tests++; if (rf_write !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL order_end got wr=%0b empty=%0b exp 0 1", rf_write, empty); end
    endtask

    task automatic test_reset_mid();
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_entry(6'b000001, 5'(20 + i), 32'h300 + 32'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_tests++; if (rf_write !== 1'b1 || count !== 3'd3) begin n_fail++; $display("FAIL mid_pre got wr=%0b cnt=%0d exp 1 3", rf_write, count); end
        #2;
        reg_reset = 1'b1;
        #1;
        n_tests++; if (rf_write !== 1'b0 || rf_read !== 1'b0) begin n_fail++; $display("FAIL mid_async_wr got wr=%0b rd=%0b exp 0 0", rf_write, rf_read); end
        n_tests++; if (count !== 3'd0 || empty !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_async_state got cnt=%0d empty=%0b rdy=%0b exp 0 1 0", count, empty, in_ready); end
        @(posedge clk);
        #1;
        reg_reset = 1'b0;
        rd_req    = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            n_tests++; if (rf_write !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL mid_after%0d got wr=%0b cnt=%0d exp 0 0", j, rf_write, count); end
        end
    endtask

`ifdef WB_FORWARD_EN
    task automatic test_forward();
        rd_req  = 1'b1;
        fwd_rs1 = 5'd9;
        fwd_rs2 = 5'd3;
        set_entry(6'b000001, 5'd9, 32'h55);
        tick();
        in_valid = 1'b0;
        n_tests++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h55) begin n_fail++; $display("FAIL fwd_hit got hit=%0b d=%h exp 1 55", fwd_hit1, fwd_data1); end
        n_tests++; if (fwd_hit2 !== 1'b0 || fwd_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_miss got hit2=%0b stall=%0b exp 0 0", fwd_hit2, fwd_stall); end
        set_entry(6'b010001, 5'd9, 32'h1234);
        tick();
        in_valid = 1'b0;
        n_tests++; if (fwd_hit1 !== 1'b0 || fwd_stall !== 1'b1) begin n_fail++; $display("FAIL fwd_partial got hit=%0b stall=%0b exp 0 1", fwd_hit1, fwd_stall); end
        rd_req = 1'b0;
        repeat (3) tick();
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fwd_drain got empty=%0b exp 1", empty); end
    endtask
`endif

    initial begin
        reg_reset = 1'b1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_rd     = '0;
        in_data   = '0;
        rd_req    = 1'b0;
`ifdef WB_FORWARD_EN
        fwd_rs1   = '0;
        fwd_rs2   = '0;
`endif
        test_reset();
        test_latency();
        test_defer();
        test_full();
        test_same_reg();
        test_reset_mid();
`ifdef WB_FORWARD_EN
        test_forward();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
